// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline types for the ID hazard scoreboard
//
// Purpose: register-index width, the per-stage scoreboard entry type and the
// bubble constant shared by the hazard scoreboard and its match helper.
// Ports: none (package).

package mips_pipe_pkg;

  localparam int REG_W = 5;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] regd;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/sb_src_match.sv
// rtl/sb_src_match.sv - compares one ID source register against every tracked stage
//
// Purpose: produces a per-stage match vector for one source operand of the
// instruction in ID. Register 0 never matches because it is hard-wired to zero.
// Ports:
//   src      in   REG_W          source register index from ID
//   src_en   in   1              operand is actually read (gates the whole vector)
//   entries  in   DEPTH entries  scoreboard contents, index 0 = EX
//   match    out  DEPTH          match[i] = stage i will write src

module sb_src_match
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic [REG_W-1:0]      src,
  input  logic                  src_en,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = src_en && (src != '0) && entries[i].valid &&
                 entries[i].regwrite && (entries[i].regd == src);
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - RAW hazard stall / branch flush control beside ID/EX
//
// Purpose: tracks the destinations of instructions issued from ID down EX..WB,
// stalls ID (and injects a bubble into ID/EX) on a RAW hazard against the ID
// sources, and flushes on a taken branch. Stall and flush are combinational
// from the registered scoreboard plus the current ID inputs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt, id_uses_rt ID source registers (rt only when id_uses_rt)
//   id_regd, id_regwrite     ID destination and write enable
//   id_memread               ID instruction is a load
//   ex_br_taken              branch resolved taken in EX this cycle
//   stall                    freeze PC and IF/ID, bubble into ID/EX
//   flush                    squash IF/ID and ID/EX
//   stall_cnt, flush_cnt     saturating event counters
// REG_W must equal mips_pipe_pkg::REG_W since the entry type is sized by it.

module id_hazard_scoreboard #(
  parameter int REG_W  = mips_pipe_pkg::REG_W,
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_regd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import mips_pipe_pkg::*;

  sb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] rs_match;
  logic      [DEPTH-1:0] rt_match;
  logic      [DEPTH-1:0] any_match;
  logic                  hazard;

  sb_src_match #(.DEPTH(DEPTH)) u_rs_match (
    .src     (id_rs),
    .src_en  (1'b1),
    .entries (entries),
    .match   (rs_match)
  );

  sb_src_match #(.DEPTH(DEPTH)) u_rt_match (
    .src     (id_rt),
    .src_en  (id_uses_rt),
    .entries (entries),
    .match   (rt_match)
  );

  assign any_match = rs_match | rt_match;

  // With forwarding only a load still in EX is unresolvable. Without it,
  // every producer ahead of WB blocks; WB itself is covered by the register
  // file's write-then-read half cycles.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (FWD_EN) begin
        hazard |= (i == 0) && any_match[i] && entries[i].memread;
      end else begin
        hazard |= (i < DEPTH - 1) && any_match[i];
      end
    end
  end

  // A taken branch squashes the ID instruction, so it never needs to stall.
  assign stall = id_valid && hazard && !ex_br_taken;
  // Held low during reset so both controls drop together.
  assign flush = ex_br_taken && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= {DEPTH{SB_BUBBLE}};
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entries[i] <= entries[i-1];
      end
      if (stall || flush) begin
        entries[0] <= SB_BUBBLE;
      end else begin
        entries[0] <= {id_valid, id_regwrite, id_memread, id_regd};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard

module tb_id_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_regd;
  logic       id_regwrite;
  logic       id_memread;
  logic       ex_br_taken;

  logic        stall_f, flush_f, stall_n, flush_n, stall_s, flush_s;
  logic [15:0] scnt_f, fcnt_f, scnt_n, fcnt_n;
  logic [3:0]  scnt_s, fcnt_s;

  id_hazard_scoreboard #(.REG_W(5), .DEPTH(3), .FWD_EN(1'b1), .CNT_W(16)) u_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_regd(id_regd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_br_taken(ex_br_taken), .stall(stall_f),
    .flush(flush_f), .stall_cnt(scnt_f), .flush_cnt(fcnt_f));

  id_hazard_scoreboard #(.REG_W(5), .DEPTH(3), .FWD_EN(1'b0), .CNT_W(16)) u_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_regd(id_regd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_br_taken(ex_br_taken), .stall(stall_n),
    .flush(flush_n), .stall_cnt(scnt_n), .flush_cnt(fcnt_n));

  id_hazard_scoreboard #(.REG_W(5), .DEPTH(4), .FWD_EN(1'b0), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_regd(id_regd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_br_taken(ex_br_taken), .stall(stall_s),
    .flush(flush_s), .stall_cnt(scnt_s), .flush_cnt(fcnt_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: hist[k][a] is what instance k issued a+1 cycles ago.
  typedef struct { bit v; bit rw; bit mr; int rd; } rec_t;
  typedef struct { bit st; bit fl; int sc; int fc; } exp_t;

  rec_t hist [3][4];
  int   m_depth [3] = '{3, 3, 4};
  bit   m_fwd   [3] = '{1'b1, 1'b0, 1'b0};
  int   m_cmax  [3] = '{65535, 65535, 15};
  int   m_sc [3];
  int   m_fc [3];
  bit   m_last_st [3];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 4; a++) hist[k][a] = '{0, 0, 0, 0};
      m_sc[k] = 0;
      m_fc[k] = 0;
    end
  endtask

  function automatic bit produces(int k, int a, int src);
    return (src != 0) && hist[k][a].v && hist[k][a].rw && (hist[k][a].rd == src);
  endfunction

  function automatic bit model_stall(int k);
    bit h = 1'b0;
    int last = m_fwd[k] ? 0 : m_depth[k] - 2;
    for (int a = 0; a <= last; a++) begin
      if ((produces(k, a, int'(id_rs)) || (id_uses_rt && produces(k, a, int'(id_rt)))) &&
          (!m_fwd[k] || hist[k][a].mr))
        h = 1'b1;
    end
    return id_valid && h && !ex_br_taken;
  endfunction

  // Present one ID instruction, push expectations, advance the model to the next edge.
  task automatic apply(input bit v, input int rs, input int rt, input bit urt,
                       input int rd, input bit rw, input bit mr, input bit br);
    exp_t e;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
    id_regd = 5'(rd); id_regwrite = rw; id_memread = mr; ex_br_taken = br;
    for (int k = 0; k < 3; k++) begin
      e.st = model_stall(k);
      e.fl = br;
      e.sc = m_sc[k];
      e.fc = m_fc[k];
      m_last_st[k] = e.st;
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
      if (e.st && m_sc[k] < m_cmax[k]) m_sc[k]++;
      if (e.fl && m_fc[k] < m_cmax[k]) m_fc[k]++;
      for (int a = 3; a > 0; a--) hist[k][a] = hist[k][a-1];
      if (e.st || e.fl) hist[k][0] = '{0, 0, 0, 0};
      else hist[k][0] = '{v, rw, mr, rd};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v, input int rs, input int rt, input bit urt,
                       input int rd, input bit rw, input bit mr, input bit br);
    apply(v, rs, rt, urt, rd, rw, mr, br);
    tick();
  endtask

  task automatic mon_one(input string tag, input exp_t e, input logic st, input logic fl,
                         input logic [31:0] sc, input logic [31:0] fc);
    chk({tag, "_stall"}, st, e.st);
    chk({tag, "_flush"}, fl, e.fl);
    chk({tag, "_stall_cnt"}, sc, e.sc);
    chk({tag, "_flush_cnt"}, fc, e.fc);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (q0.size() != 0) mon_one("fwd", q0.pop_front(), stall_f, flush_f, 32'(scnt_f), 32'(fcnt_f));
      if (q1.size() != 0) mon_one("nofwd", q1.pop_front(), stall_n, flush_n, 32'(scnt_n), 32'(fcnt_n));
      if (q2.size() != 0) mon_one("sat", q2.pop_front(), stall_s, flush_s, 32'(scnt_s), 32'(fcnt_s));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_regd = 0; id_regwrite = 0; id_memread = 0; ex_br_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", stall_f, 0);
    chk("reset_flush", flush_f, 0);
    chk("reset_stall_cnt", 32'(scnt_f), 0);
    chk("reset_flush_cnt", 32'(fcnt_n), 0);
    rst = 1'b0;

    // Load-use: lw r8 then add r9,r8,r2 held in ID.
    issue(1, 1, 8, 0, 8, 1, 1, 0);
    repeat (3) issue(1, 8, 2, 1, 9, 1, 0, 0);
    chk("loaduse_fwd_stall_cnt", 32'(scnt_f), 1);
    chk("loaduse_nofwd_stall_cnt", 32'(scnt_n), 2);
    chk("loaduse_d4_stall_cnt", 32'(scnt_s), 3);
    repeat (4) issue(0, 0, 0, 0, 0, 0, 0, 0);

    // ALU producer then reader.
    issue(1, 1, 2, 1, 8, 1, 0, 0);
    repeat (3) issue(1, 8, 2, 1, 9, 1, 0, 0);
    repeat (4) issue(0, 0, 0, 0, 0, 0, 0, 0);

    // Register 0 never matches; unused rt never matches.
    issue(1, 1, 0, 0, 0, 1, 1, 0);
    repeat (2) issue(1, 0, 0, 1, 3, 1, 0, 0);
    issue(1, 1, 8, 0, 8, 1, 1, 0);
    issue(1, 2, 8, 0, 4, 1, 0, 0);
    repeat (4) issue(0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use coinciding with a taken branch; the next entry must be a bubble.
    issue(1, 1, 8, 0, 8, 1, 1, 0);
    issue(1, 8, 0, 0, 8, 1, 1, 1);
    chk("branch_flush_cnt", 32'(fcnt_f), 1);
    issue(1, 8, 2, 1, 9, 1, 0, 0);
    repeat (4) issue(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset pulsed while a stall is being asserted.
    issue(1, 1, 8, 0, 8, 1, 1, 0);
    apply(1, 8, 2, 1, 9, 1, 0, 0);
    #6;
    rst = 1'b1;
    #1;
    chk("midrst_stall_fwd", stall_f, 0);
    chk("midrst_stall_nofwd", stall_n, 0);
    chk("midrst_flush", flush_f, 0);
    chk("midrst_stall_cnt", 32'(scnt_f), 0);
    chk("midrst_flush_cnt", 32'(fcnt_f), 0);
    chk("midrst_stall_cnt_n", 32'(scnt_n), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    issue(1, 8, 2, 1, 9, 1, 0, 0);

    // Saturation of the 4-bit instance: at least 2^4+3 stall cycles.
    seen = 0;
    for (int c = 0; c < 300 && seen < 19; c++) begin
      issue(1, 8, 0, 0, 8, 1, 1, 0);
      if (m_last_st[2]) seen++;
    end
    n_chk++;
    if (seen < 19) begin
      n_fail++;
      $display("FAIL sat_bound: got %0d stall cycles expected 19", seen);
    end
    chk("sat_stall_cnt", 32'(scnt_s), 15);

    // Randomized traffic with a small register pool so hazards are frequent.
    for (int c = 0; c < 600; c++) begin
      issue($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10);
    end

    n_chk++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations expected 0", q0.size() + q1.size() + q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
